trs_cmd_parser: RTL

Parametrised successor to the /CMD program loader. Consumes the HPS download byte stream and parses TRS-80 /CMD records (load blocks, transfer address, comments, unknown types) or raw binary images. Emits memory writes through a ready/valid handshake with backpressure to the download source, and raises execute requests. Sits between hps_io and the download mux ahead of the machine core; replaces the fixed-width, no-backpressure loader.

---
 rtl/trs_loader_pkg.sv | 50 +++++
 rtl/trs_wr_slot.sv | 48 ++++
 rtl/trs_cmd_parser.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/trs_loader_pkg.sv
// Shared definitions for the TRS-80 download parser.
// Contents:
//   state_t           parser states
//   REC_* constants   /CMD record type bytes
//   ERR_* positions   bit positions inside the parser's sticky error vector
//   load_count()      data byte count of a load record from its length byte
//   skip_count()      byte count of a skipped record from its length byte
package trs_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TYPE,
    ST_LEN,
    ST_ADDR_LO,
    ST_ADDR_HI,
    ST_DATA,
    ST_XFER_LEN,
    ST_XFER_LO,
    ST_XFER_HI,
    ST_SKIP,
    ST_RAW,
    ST_DONE
  } state_t;

  localparam logic [7:0] REC_LOAD    = 8'h01;
  localparam logic [7:0] REC_XFER    = 8'h02;
  localparam logic [7:0] REC_COMMENT = 8'h05;

  localparam int ERR_OVERRUN = 0;
  localparam int ERR_TRUNC   = 1;
  localparam int ERR_W       = 2;

  // The load length byte counts the two address bytes as well, so the
  // payload is len-2. Values 0, 1 and 2 wrap around to 254, 255 and 256.
  function automatic logic [8:0] load_count(input logic [7:0] len);
    if (len <= 8'd2) begin
      return 9'd254 + {1'b0, len};
    end
    return {1'b0, len} - 9'd2;
  endfunction

  // Skipped records carry len bytes, with zero standing for a full 256.
  function automatic logic [8:0] skip_count(input logic [7:0] len);
    if (len == 8'd0) begin
      return 9'd256;
    end
    return {1'b0, len};
  endfunction

endpackage

// File: rtl/trs_wr_slot.sv
// Single-entry write holding register between the parser and memory.
// Ports:
//   clk_sys, reset_n       clock, asynchronous active-low reset
//   load                   capture load_addr/load_data and raise mem_wr
//   load_addr, load_data   write to be held
//   mem_ready              memory accepts the held write this cycle
//   mem_wr, mem_addr,      held write, stable until accepted
//   mem_data
//   busy                   a write is held and is not leaving this cycle
//   ioctl_wait             backpressure to the download source
module trs_wr_slot #(
  parameter int ADDR_W = 16
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  input  logic              mem_ready,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              busy,
  output logic              ioctl_wait
);

  // A new load may land in the same cycle the previous write is accepted,
  // so load takes priority over the ready-driven clear.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mem_wr   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else if (load) begin
      mem_wr   <= 1'b1;
      mem_addr <= load_addr;
      mem_data <= load_data;
    end else if (mem_ready) begin
      mem_wr   <= 1'b0;
    end
  end

  // The slot frees up in the cycle mem_ready is seen, so a byte arriving
  // alongside mem_ready is still accepted.
  assign busy       = mem_wr && !mem_ready;
  assign ioctl_wait = mem_wr;

endmodule

// File: rtl/trs_cmd_parser.sv
// TRS-80 /CMD and raw binary download parser.
// Consumes the hps_io download byte stream, parses /CMD records (load,
// transfer address, skipped types) or writes raw images linearly, and
// issues memory writes through a single-entry slot with backpressure.
// Ports:
//   clk_sys, reset_n                  clock, asynchronous active-low reset
//   ioctl_download, ioctl_index,      hps_io download interface
//   ioctl_wr, ioctl_dout, ioctl_wait
//   loader_download                   parser owns the memory bus
//   mem_wr, mem_ready, mem_addr,      memory write handshake
//   mem_data
//   execute_addr, execute_enable      transfer address and execute pulse
//   block_count                       completed load blocks, saturating
//   err_overrun, err_trunc            sticky error flags
module trs_cmd_parser
  import trs_loader_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter logic [7:0]  CMD_INDEX = 8'd2,
  parameter logic [7:0]  RAW_INDEX = 8'd3,
  parameter logic [15:0] RAW_BASE  = 16'h5200,
  parameter int          AUTO_EXEC = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              loader_download,
  output logic              mem_wr,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic [15:0]       execute_addr,
  output logic              execute_enable,
  output logic [7:0]        block_count,
  output logic              err_overrun,
  output logic              err_trunc
);

  state_t            state_q, state_d;
  logic              selected;
  logic              active;
  logic              slot_busy;
  logic              slot_load;
  logic              byte_take;
  logic              end_req;
  logic              trunc_set;
  logic              overrun;
  logic              is_cmd_q;
  logic              skip_q;
  logic              xfer_seen_q;
  logic [8:0]        count_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ERR_W-1:0]  err_q;
  logic [7:0]        block_count_q;
  logic [15:0]       exec_addr_q;

  assign selected = ioctl_download &&
                    (ioctl_index == CMD_INDEX || ioctl_index == RAW_INDEX);
  assign active   = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign end_req  = active && !ioctl_download;
  assign overrun  = active && ioctl_wr && slot_busy;

  trs_wr_slot #(.ADDR_W(ADDR_W)) u_slot (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .load       (slot_load),
    .load_addr  (addr_q),
    .load_data  (ioctl_dout),
    .mem_ready  (mem_ready),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .busy       (slot_busy),
    .ioctl_wait (ioctl_wait)
  );

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. End of download waits for the slot to drain before
  // entering DONE; ending anywhere but at a record boundary is a truncation.
  always_comb begin
    state_d   = state_q;
    slot_load = 1'b0;
    byte_take = 1'b0;
    trunc_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (selected) begin
          state_d = (ioctl_index == CMD_INDEX) ? ST_TYPE : ST_RAW;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        if (end_req) begin
          if (!mem_wr) begin
            state_d   = ST_DONE;
            trunc_set = (state_q != ST_TYPE) && (state_q != ST_RAW);
          end
        end else if (ioctl_wr && !slot_busy) begin
          byte_take = 1'b1;
          case (state_q)
            ST_TYPE: begin
              state_d = (ioctl_dout == REC_XFER) ? ST_XFER_LEN : ST_LEN;
            end
            ST_LEN:      state_d = skip_q ? ST_SKIP : ST_ADDR_LO;
            ST_ADDR_LO:  state_d = ST_ADDR_HI;
            ST_ADDR_HI:  state_d = ST_DATA;
            ST_DATA: begin
              slot_load = 1'b1;
              if (count_q == 9'd1) begin
                state_d = ST_TYPE;
              end
            end
            ST_XFER_LEN: state_d = ST_XFER_LO;
            ST_XFER_LO:  state_d = ST_XFER_HI;
            ST_XFER_HI:  state_d = ST_TYPE;
            ST_SKIP: begin
              if (count_q == 9'd1) begin
                state_d = ST_TYPE;
              end
            end
            ST_RAW:      slot_load = 1'b1;
            default:     state_d = state_q;
          endcase
        end
      end
    endcase
  end

  // Parser datapath: record type, byte counter, address counter, transfer
  // address, block count and sticky errors. Everything per-download is
  // re-armed on the first selected cycle while still IDLE.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      is_cmd_q      <= 1'b0;
      skip_q        <= 1'b0;
      xfer_seen_q   <= 1'b0;
      count_q       <= '0;
      addr_q        <= '0;
      err_q         <= '0;
      block_count_q <= '0;
      exec_addr_q   <= '0;
    end else begin
      if (state_q == ST_IDLE && selected) begin
        is_cmd_q    <= (ioctl_index == CMD_INDEX);
        skip_q      <= 1'b0;
        xfer_seen_q <= 1'b0;
        err_q       <= '0;
        addr_q      <= ADDR_W'(RAW_BASE);
      end
      if (overrun) begin
        err_q[ERR_OVERRUN] <= 1'b1;
      end
      if (trunc_set) begin
        err_q[ERR_TRUNC] <= 1'b1;
      end
      if (byte_take) begin
        case (state_q)
          ST_TYPE:    skip_q <= (ioctl_dout != REC_LOAD);
          ST_LEN:     count_q <= skip_q ? skip_count(ioctl_dout)
                                        : load_count(ioctl_dout);
          ST_ADDR_LO: addr_q <= ADDR_W'(ioctl_dout);
          ST_ADDR_HI: addr_q <= ADDR_W'({ioctl_dout, addr_q[7:0]});
          ST_DATA: begin
            addr_q  <= addr_q + ADDR_W'(1);
            count_q <= count_q - 9'd1;
            if (count_q == 9'd1 && block_count_q != 8'hFF) begin
              block_count_q <= block_count_q + 8'd1;
            end
          end
          ST_XFER_LO: exec_addr_q[7:0] <= ioctl_dout;
          ST_XFER_HI: begin
            exec_addr_q[15:8] <= ioctl_dout;
            xfer_seen_q       <= 1'b1;
          end
          ST_SKIP:    count_q <= count_q - 9'd1;
          ST_RAW:     addr_q  <= addr_q + ADDR_W'(1);
          default:    count_q <= count_q;
        endcase
      end
    end
  end

  assign loader_download = (state_q != ST_IDLE);
  assign execute_enable  = (state_q == ST_DONE) && is_cmd_q && (AUTO_EXEC != 0) &&
                           xfer_seen_q && !err_q[ERR_TRUNC];
  assign execute_addr    = exec_addr_q;
  assign block_count     = block_count_q;
  assign err_overrun     = err_q[ERR_OVERRUN];
  assign err_trunc       = err_q[ERR_TRUNC];

endmodule
